// File: rtl/alu_pkg.sv
// Shared types for the 8-bit day4 ALU and its response checker.
// Holds the opcode map, checker FSM states and the datapath width.
package alu_pkg;

    localparam int ALU_W = 8;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        SLL = 3'd2,
        LSR = 3'd3,
        AND = 3'd4,
        OR  = 3'd5,
        XOR = 3'd6,
        EQL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } chk_state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden model of the day4 ALU (mod-256 results).
// Ports: a, b operands, op opcode -> expected result.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [2:0]       op,
    output logic [ALU_W-1:0] expected
);

    always_comb begin
        expected = '0;
        unique case (alu_op_e'(op))
            ADD:     expected = a + b;
            SUB:     expected = a - b;
            SLL:     expected = a << b[2:0];
            LSR:     expected = a >> b[2:0];
            AND:     expected = a & b;
            OR:      expected = a | b;
            XOR:     expected = a ^ b;
            EQL:     expected = {{(ALU_W-1){1'b0}}, a == b};
            default: expected = '0;
        endcase
    end

endmodule

// File: rtl/alu_resp_checker.sv
// Checks ALU responses against the golden model, counts passes/errors
// and latches the first mismatch. Ports: start/handshake in, status out.
module alu_resp_checker
    import alu_pkg::*;
#(
    parameter int NUM_TXN = 21
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             txn_valid_i,
    output logic             txn_ready_o,
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    input  logic [2:0]       op_i,
    input  logic [ALU_W-1:0] res_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [15:0]      txn_cnt_o,
    output logic [15:0]      err_cnt_o,
    output logic             first_err_vld_o,
    output logic [2:0]       first_err_op_o,
    output logic [ALU_W-1:0] first_err_exp_o,
    output logic [ALU_W-1:0] first_err_got_o
);

    localparam logic [15:0] LAST_ACC = 16'(NUM_TXN - 1);

    chk_state_e       state, state_n;
    logic [15:0]      acc_cnt;
    logic             cmp_vld;
    logic [ALU_W-1:0] cmp_a;
    logic [ALU_W-1:0] cmp_b;
    logic [2:0]       cmp_op;
    logic [ALU_W-1:0] cmp_res;
    logic [ALU_W-1:0] cmp_exp;
    logic             accept;
    logic             start_go;
    logic             mismatch;

    alu_ref_model u_ref (
        .a        (cmp_a),
        .b        (cmp_b),
        .op       (cmp_op),
        .expected (cmp_exp)
    );

    assign accept   = txn_valid_i && (state == ST_RUN);
    assign start_go = start_i &&
                      (state == ST_IDLE || state == ST_DONE);
    assign mismatch = cmp_vld && (cmp_res != cmp_exp);

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE, ST_DONE: if (start_i) state_n = ST_RUN;
            // acc_cnt counts accepts so far; the compare stage lags
            ST_RUN: if (accept && acc_cnt == LAST_ACC) state_n = ST_DRAIN;
            ST_DRAIN: state_n = ST_DONE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            acc_cnt         <= '0;
            cmp_vld         <= 1'b0;
            cmp_a           <= '0;
            cmp_b           <= '0;
            cmp_op          <= '0;
            cmp_res         <= '0;
            txn_cnt_o       <= '0;
            err_cnt_o       <= '0;
            first_err_vld_o <= 1'b0;
            first_err_op_o  <= '0;
            first_err_exp_o <= '0;
            first_err_got_o <= '0;
        end else begin
            state   <= state_n;
            cmp_vld <= accept;
            if (accept) begin
                cmp_a   <= a_i;
                cmp_b   <= b_i;
                cmp_op  <= op_i;
                cmp_res <= res_i;
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (start_go) begin
                acc_cnt         <= '0;
                txn_cnt_o       <= '0;
                err_cnt_o       <= '0;
                first_err_vld_o <= 1'b0;
                first_err_op_o  <= '0;
                first_err_exp_o <= '0;
                first_err_got_o <= '0;
            end else if (cmp_vld) begin
                txn_cnt_o <= txn_cnt_o + 16'd1;
                if (mismatch && err_cnt_o != 16'hFFFF)
                    err_cnt_o <= err_cnt_o + 16'd1;
                if (mismatch && !first_err_vld_o) begin
                    first_err_vld_o <= 1'b1;
                    first_err_op_o  <= cmp_op;
                    first_err_exp_o <= cmp_exp;
                    first_err_got_o <= cmp_res;
                end
            end
        end
    end

    assign txn_ready_o = (state == ST_RUN);
    assign busy_o      = (state == ST_RUN);
    assign done_o      = (state == ST_DONE);
    assign pass_o      = done_o && (err_cnt_o == 16'd0);

endmodule

// File: tb/tb_alu_resp_checker.sv
// Directed self-checking bench for alu_resp_checker (NUM_TXN=7).
// Covers reset, pass/fail runs, valid gaps, mid-run reset and restart.
module tb_alu_resp_checker;

    typedef struct packed {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       bad;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        txn_valid_i = 1'b0;
    logic        txn_ready_o;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic [2:0]  op_i = '0;
    logic [7:0]  res_i = '0;
    logic        busy_o;
    logic        done_o;
    logic        pass_o;
    logic [15:0] txn_cnt_o;
    logic [15:0] err_cnt_o;
    logic        first_err_vld_o;
    logic [2:0]  first_err_op_o;
    logic [7:0]  first_err_exp_o;
    logic [7:0]  first_err_got_o;

    int n_run  = 0;
    int n_fail = 0;

    // 0..6: correct results for ops 0..6; 7..13: mixed run, 3 wrong
    vec_t tbl [14] = '{
        '{3'd0, 8'hF0, 8'h20, 8'h10, 1'b0},
        '{3'd1, 8'h10, 8'h30, 8'hE0, 1'b0},
        '{3'd2, 8'h03, 8'h04, 8'h30, 1'b0},
        '{3'd3, 8'h80, 8'h0B, 8'h10, 1'b0},
        '{3'd4, 8'hF0, 8'h3C, 8'h30, 1'b0},
        '{3'd5, 8'hF0, 8'h0F, 8'hFF, 1'b0},
        '{3'd6, 8'hAA, 8'hFF, 8'h55, 1'b0},
        '{3'd2, 8'h81, 8'h09, 8'h04, 1'b1},
        '{3'd7, 8'h5A, 8'h5A, 8'h01, 1'b0},
        '{3'd1, 8'h00, 8'h01, 8'hFF, 1'b0},
        '{3'd0, 8'h01, 8'h01, 8'h03, 1'b1},
        '{3'd6, 8'h0F, 8'hF0, 8'h00, 1'b1},
        '{3'd4, 8'hFF, 8'h0F, 8'h0F, 1'b0},
        '{3'd5, 8'h00, 8'h00, 8'h00, 1'b0}
    };

    alu_resp_checker #(.NUM_TXN(7)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .txn_valid_i     (txn_valid_i),
        .txn_ready_o     (txn_ready_o),
        .a_i             (a_i),
        .b_i             (b_i),
        .op_i            (op_i),
        .res_i           (res_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .pass_o          (pass_o),
        .txn_cnt_o       (txn_cnt_o),
        .err_cnt_o       (err_cnt_o),
        .first_err_vld_o (first_err_vld_o),
        .first_err_op_o  (first_err_op_o),
        .first_err_exp_o (first_err_exp_o),
        .first_err_got_o (first_err_got_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input vec_t t);
        txn_valid_i = v;
        op_i  = t.op;
        a_i   = t.a;
        b_i   = t.b;
        res_i = t.res;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, ".ready"}, 32'(txn_ready_o), 0);
        chk({tag, ".busy"}, 32'(busy_o), 0);
        chk({tag, ".done"}, 32'(done_o), 0);
        chk({tag, ".pass"}, 32'(pass_o), 0);
        chk({tag, ".txn"}, 32'(txn_cnt_o), 0);
        chk({tag, ".err"}, 32'(err_cnt_o), 0);
        chk({tag, ".fe_vld"}, 32'(first_err_vld_o), 0);
        chk({tag, ".fe_op"}, 32'(first_err_op_o), 0);
        chk({tag, ".fe_exp"}, 32'(first_err_exp_o), 0);
        chk({tag, ".fe_got"}, 32'(first_err_got_o), 0);
    endtask

    task automatic do_start(input string tag);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk({tag, ".busy"}, 32'(busy_o), 1);
        chk({tag, ".ready"}, 32'(txn_ready_o), 1);
        chk({tag, ".txn"}, 32'(txn_cnt_o), 0);
        chk({tag, ".err"}, 32'(err_cnt_o), 0);
        chk({tag, ".fe_vld"}, 32'(first_err_vld_o), 0);
        chk({tag, ".fe_op"}, 32'(first_err_op_o), 0);
        chk({tag, ".fe_exp"}, 32'(first_err_exp_o), 0);
        chk({tag, ".fe_got"}, 32'(first_err_got_o), 0);
    endtask

    // 7 back-to-back accepts; mid_start >= 0 also pulses start_i there
    task automatic run_b2b(input string tag, input int base,
                           input int mid_start);
        int e = 0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, tbl[base+i]);
            start_i = (i == mid_start);
            tick();
            start_i = 1'b0;
            chk({tag, ".txn"}, 32'(txn_cnt_o), 32'(i));
            chk({tag, ".err"}, 32'(err_cnt_o), 32'(e));
            chk({tag, ".ready"}, 32'(txn_ready_o), 32'(i < 6));
            if (tbl[base+i].bad) e++;
        end
        txn_valid_i = 1'b0;
        chk({tag, ".drain_busy"}, 32'(busy_o), 0);
        chk({tag, ".drain_done"}, 32'(done_o), 0);
        tick();
        chk({tag, ".done"}, 32'(done_o), 1);
        chk({tag, ".busy"}, 32'(busy_o), 0);
        chk({tag, ".txn_fin"}, 32'(txn_cnt_o), 7);
        chk({tag, ".err_fin"}, 32'(err_cnt_o), 32'(e));
        chk({tag, ".pass"}, 32'(pass_o), 32'(e == 0));
    endtask

    initial begin
        tick();
        tick();
        chk_cleared("rst");
        reset = 1'b0;
        tick();
        chk_cleared("idle");

        do_start("start1");
        run_b2b("good", 0, -1);

        do_start("start2");
        run_b2b("bad", 7, 3);
        chk("bad.fe_vld", 32'(first_err_vld_o), 1);
        chk("bad.fe_op", 32'(first_err_op_o), 2);
        chk("bad.fe_exp", 32'(first_err_exp_o), 32'h02);
        chk("bad.fe_got", 32'(first_err_got_o), 32'h04);

        do_start("restart");
        for (int k = 0; k < 7; k++) begin
            drive(1'b0, tbl[k]);
            tick();
            tick();
            chk("gap.txn", 32'(txn_cnt_o), 32'(k));
            drive(1'b1, tbl[k]);
            tick();
            chk("gap.ready", 32'(txn_ready_o), 32'(k < 6));
        end
        drive(1'b1, tbl[7]);
        tick();
        tick();
        tick();
        txn_valid_i = 1'b0;
        chk("gap.done", 32'(done_o), 1);
        chk("gap.txn_fin", 32'(txn_cnt_o), 7);
        chk("gap.err_fin", 32'(err_cnt_o), 0);
        chk("gap.pass", 32'(pass_o), 1);

        do_start("start4");
        drive(1'b1, tbl[8]);
        tick();
        drive(1'b1, tbl[9]);
        tick();
        drive(1'b1, tbl[7]);
        tick();
        chk("mid.txn", 32'(txn_cnt_o), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        txn_valid_i = 1'b0;
        chk_cleared("midrst");
        tick();
        chk_cleared("postrst");
        do_start("start5");
        run_b2b("after", 0, -1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_resp_checker.md
# alu_resp_checker

Synthesizable response checker that sits on the result side of the 8-bit `day4` ALU. Each accepted transaction carries operands, opcode and the ALU's observed result. The block recomputes the expected result with an internal golden model and keeps pass/error counters. It also latches the first mismatch for debug and stops accepting after a programmed number of transactions. It lets the ALU be self-checked in simulation or on FPGA without a behavioural scoreboard.

## Interface
- `NUM_TXN`, default 21: transactions to check per run (1..65535).
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start_i` input 1: one-cycle pulse; clears counters and the first-error record, then enters RUN.
- `txn_valid_i` input 1: transaction present.
- `txn_ready_o` output 1: checker can accept.
- `a_i` input 8: operand A as driven to the ALU.
- `b_i` input 8: operand B.
- `op_i` input 3: opcode.
- `res_i` input 8: ALU output `alu_o` for this transaction.
- `busy_o` output 1: state is RUN.
- `done_o` output 1: state is DONE.
- `pass_o` output 1: `done_o && err_cnt_o == 0`.
- `txn_cnt_o` output 16: transactions compared.
- `err_cnt_o` output 16: mismatches; saturates at 16'hFFFF.
- `first_err_vld_o` output 1: a mismatch has been recorded.
- `first_err_op_o` output 3: opcode of the first mismatch.
- `first_err_exp_o` output 8: expected value of the first mismatch.
- `first_err_got_o` output 8: observed value of the first mismatch.

## Operation
- Opcode map and golden model, all results 8-bit with mod-256 wrap:
  - ADD=0: a+b
  - SUB=1: a−b
  - SLL=2: a<<b[2:0]
  - LSR=3: a>>b[2:0], logical
  - AND=4, OR=5, XOR=6
  - EQL=7: {7'b0, a==b}
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start_i`.
  - RUN → DRAIN on the handshake that accepts transaction number NUM_TXN.
  - DRAIN → DONE when the final compare commits, one cycle later.
  - DONE → RUN on `start_i`.
- `txn_ready_o` = state==RUN. It is low in IDLE, DRAIN and DONE.
- Accept occurs when `txn_valid_i && txn_ready_o` at a rising edge. Operands, opcode and result are registered into the compare stage. Inputs are ignored when not accepted.
- Compare stage, one cycle after accept:
  - `txn_cnt_o` increments.
  - On mismatch, `err_cnt_o` increments (saturating).
  - On a mismatch with `first_err_vld_o`==0, the first-error fields are loaded and `first_err_vld_o` is set. Later mismatches do not overwrite them.
- `start_i` in RUN or DRAIN is ignored. `start_i` in IDLE or DONE clears all counters and first-error fields in the same edge that enters RUN.

## Timing
- Reset values:
  - State IDLE.
  - All counters, first-error fields and `first_err_vld_o` = 0.
  - `txn_ready_o`, `busy_o`, `done_o`, `pass_o` = 0.
- Latency: a transaction accepted at edge N is reflected in counters after edge N+1.
- Throughput: one transaction per cycle with `txn_valid_i` held high. NUM_TXN back-to-back transactions reach DONE at edge NUM_TXN+1 after the first accept.
- `done_o` asserts in the same cycle that the final `txn_cnt_o`==NUM_TXN value is visible.
- `reset` asserted mid-run takes priority over `start_i` and handshakes. It discards any in-flight compare, and all outputs return to their reset values on that edge.
- NUM_TXN=1: accept → DRAIN → DONE.

## Structure
- Package `alu_pkg`:
  - `typedef enum logic [2:0] alu_op_e` with ADD, SUB, SLL, LSR, AND, OR, XOR, EQL.
  - Checker state enum.
  - `localparam ALU_W = 8`.
- Sub-module `alu_ref_model`: purely combinational golden model (a, b, op → expected). It is shared with future ALU benches.

## Test plan
- Reset, then `start_i`; 7 back-to-back transactions with ops 0..6 and correct results (e.g. ADD 8'hF0+8'h20 → 8'h10), NUM_TXN=7 → `done_o`=1 at edge 8, `pass_o`=1, `txn_cnt_o`=7, `err_cnt_o`=0.
- Inject a wrong result: op SLL, a=8'h81, b=8'h09, res=8'h04 (expected 8'h02), followed by 2 more wrong results → `err_cnt_o`=3; first-error fields hold op=2, exp=8'h02, got=8'h04.
- Gaps in `txn_valid_i` (valid every 3rd cycle): counters advance only on handshakes; `txn_ready_o` drops exactly after the NUM_TXN-th accept; further valid cycles are not counted.
- Assert `reset` in RUN after 3 accepts, with a compare in flight → the next cycle shows all outputs zero and state IDLE; a subsequent `start_i` run counts from 0.
- From DONE with errors recorded, pulse `start_i` → counters and first-error fields clear on that edge; `start_i` pulsed again mid-RUN has no effect.
- EQL with a=b=8'h5A, res=8'h01 passes; SUB with a=8'h00, b=8'h01, res=8'hFF passes (wrap).
